// File: rtl/regbank_access_ctrl_if.sv
// Decode-side and execute-side handshake bundle for regbank_access_ctrl.
interface regbank_access_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_use_rs;
  logic        in_use_rt;
  logic        in_wr_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_wr_rd;

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wr_rd, out_ready,
    output in_ready, out_valid, out_a, out_b, out_rd, out_wr_rd
  );

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_use_rs, in_use_rt, in_wr_rd, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_rd, out_wr_rd
  );
endinterface

// File: rtl/regbank_access_ctrl.sv
// Operand fetch / writeback initiator for the register bank, with a
// per-register pending-write scoreboard and saturating hazard-stall counter.
module regbank_access_ctrl #(
  parameter int unsigned NREGS = 17,
  parameter int unsigned CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  regbank_access_ctrl_if.slave bus,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_reg,
  input  logic [31:0]          wb_data,
  output logic [4:0]           rb_inport1,
  output logic [4:0]           rb_inport2,
  output logic                 rb_read1,
  output logic                 rb_read2,
  input  logic [31:0]          rb_R1,
  input  logic [31:0]          rb_R2,
  output logic                 rb_write,
  output logic [4:0]           rb_wport,
  output logic [31:0]          rb_R3,
  output logic [CNTW-1:0]      stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, state_nxt;

  logic [4:0]       rs_q, rt_q, rd_q;
  logic             use_rs_q, use_rt_q, wr_rd_q;
  logic [NREGS-1:0] pend, pend_set, pend_clr;
  logic [4:0]       addr1_q, addr2_q;
  logic [31:0]      a_q, b_q;
  logic [4:0]       out_rd_q;
  logic             out_wr_rd_q;
  logic             wb_v_q;
  logic [4:0]       wb_reg_q;
  logic [31:0]      wb_data_q;
  logic             hazard, fetch_go, rs_ok, rt_ok;

  function automatic logic in_range(input logic [4:0] idx);
    return {27'd0, idx} < NREGS;
  endfunction

  // Loop-based lookup keeps out-of-range indices reading as not-pending
  function automatic logic is_pend(input logic [NREGS-1:0] p, input logic [4:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++)
      if ({27'd0, idx} == i) r = p[i];
    return r;
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [4:0] idx);
    logic [NREGS-1:0] oh;
    oh = '0;
    for (int unsigned i = 1; i < NREGS; i++)
      if ({27'd0, idx} == i) oh[i] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    rs_ok    = in_range(rs_q);
    rt_ok    = in_range(rt_q);
    hazard   = (use_rs_q & is_pend(pend, rs_q)) |
               (use_rt_q & is_pend(pend, rt_q)) |
               (wr_rd_q  & is_pend(pend, rd_q));
    fetch_go = (state == FETCH) & ~hazard;
    pend_set = (fetch_go & wr_rd_q) ? onehot(rd_q) : '0;
    pend_clr = wb_v_q ? onehot(wb_reg_q) : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = FETCH;
      FETCH:   if (!hazard)       state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rb_read1   = fetch_go & use_rs_q & rs_ok;
    rb_read2   = fetch_go & use_rt_q & rt_ok;
    rb_inport1 = fetch_go ? rs_q : addr1_q;
    rb_inport2 = fetch_go ? rt_q : addr2_q;
    rb_write   = wb_v_q & (wb_reg_q != 5'd0) & in_range(wb_reg_q);
    rb_wport   = wb_reg_q;
    rb_R3      = wb_data_q;
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_wr_rd = out_wr_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      use_rs_q    <= 1'b0;
      use_rt_q    <= 1'b0;
      wr_rd_q     <= 1'b0;
      pend        <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_rd_q    <= '0;
      out_wr_rd_q <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.in_valid) begin
        rs_q     <= bus.in_rs;
        rt_q     <= bus.in_rt;
        rd_q     <= bus.in_rd;
        use_rs_q <= bus.in_use_rs;
        use_rt_q <= bus.in_use_rt;
        wr_rd_q  <= bus.in_wr_rd;
      end
      if (fetch_go) begin
        addr1_q     <= rs_q;
        addr2_q     <= rt_q;
        a_q         <= (use_rs_q & rs_ok) ? rb_R1 : '0;
        b_q         <= (use_rt_q & rt_ok) ? rb_R2 : '0;
        out_rd_q    <= rd_q;
        out_wr_rd_q <= wr_rd_q;
      end
      // Set is applied after clear so a same-edge collision leaves the bit set
      pend   <= (pend & ~pend_clr) | pend_set;
      wb_v_q <= wb_valid;
      if (wb_valid) begin
        wb_reg_q  <= wb_reg;
        wb_data_q <= wb_data;
      end
      if (state == FETCH && hazard && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed bench for regbank_access_ctrl with a small behavioural bank model.
module tb_regbank_access_ctrl;
  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  rb_inport1, rb_inport2, rb_wport;
  logic        rb_read1, rb_read2, rb_write;
  logic [31:0] rb_R1, rb_R2, rb_R3;
  logic [15:0] stall_cnt;
  logic [31:0] bank [0:31];
  int          total = 0;
  int          bad   = 0;

  regbank_access_ctrl_if bus ();

  regbank_access_ctrl #(.NREGS(17), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .rb_inport1(rb_inport1), .rb_inport2(rb_inport2),
    .rb_read1(rb_read1), .rb_read2(rb_read2),
    .rb_R1(rb_R1), .rb_R2(rb_R2),
    .rb_write(rb_write), .rb_wport(rb_wport), .rb_R3(rb_R3),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank preset: register i holds i+1
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'(i + 1);
    end else if (rb_write) begin
      bank[rb_wport] <= rb_R3;
    end
  end
  assign rb_R1 = bank[rb_inport1];
  assign rb_R2 = bank[rb_inport2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic wrd);
    bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_use_rs = urs; bus.in_use_rt = urt; bus.in_wr_rd = wrd;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_use_rs = 1'b0; bus.in_use_rt = 1'b0; bus.in_wr_rd = 1'b0;

    // Reset
    step();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_a", bus.out_a, 0);
    check("rst_rd_en", 32'({rb_read1, rb_read2, rb_write}), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_pend", 32'(dut.pend), 0);
    step();
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 1);

    // Basic fetch
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
    check("f1_rd_en", 32'({rb_read1, rb_read2}), 3);
    check("f1_addr", 32'({rb_inport1, rb_inport2}), 32'({5'd1, 5'd2}));
    check("f1_in_ready", 32'(bus.in_ready), 0);
    check("f1_out_valid", 32'(bus.out_valid), 0);
    step();
    check("f1_hold_valid", 32'(bus.out_valid), 1);
    check("f1_out_a", bus.out_a, 2);
    check("f1_out_b", bus.out_b, 3);
    check("f1_out_rd", 32'({bus.out_wr_rd, bus.out_rd}), 32'({1'b1, 5'd5}));
    check("f1_pend", 32'(dut.pend), 32'h20);
    check("f1_stall", 32'(stall_cnt), 0);
    check("f1_hold_rd_en", 32'(rb_read1), 0);
    release_out();

    // RAW on r5, resolved by writeback
    issue(5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    check("raw_rd_en", 32'(rb_read1), 0);
    repeat (3) step();
    check("raw_stall3", 32'(stall_cnt), 3);
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;
    check("raw_wr", 32'({rb_write, rb_wport}), 32'({1'b1, 5'd5}));
    check("raw_wdata", rb_R3, 32'h77);
    check("raw_stall4", 32'(stall_cnt), 4);
    check("raw_pend_held", 32'(dut.pend), 32'h20);
    step();
    check("raw_pend_clr", 32'(dut.pend), 0);
    check("raw_fetch", 32'({rb_read1, rb_inport1}), 32'({1'b1, 5'd5}));
    check("raw_wr_done", 32'(rb_write), 0);
    step();
    check("raw_out_a", bus.out_a, 32'h77);
    check("raw_out_b", bus.out_b, 0);
    check("raw_stall5", 32'(stall_cnt), 5);
    release_out();

    // WAW on r4
    issue(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    step();
    check("waw_pend1", 32'(dut.pend), 32'h10);
    release_out();
    issue(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    step();
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    step();
    wb_valid = 1'b0;
    step();
    check("waw_pend_clr", 32'(dut.pend), 0);
    check("waw_valid_wait", 32'(bus.out_valid), 0);
    step();
    check("waw_pend_reset", 32'(dut.pend), 32'h10);
    check("waw_stall", 32'(stall_cnt), 8);
    check("waw_out_rd", 32'(bus.out_rd), 4);
    release_out();

    // Same-edge set and clear on r6
    wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'h66;
    issue(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1);
    wb_valid = 1'b0;
    check("sc_wr", 32'({rb_write, rb_wport}), 32'({1'b1, 5'd6}));
    step();
    check("sc_pend", 32'(dut.pend), 32'h50);
    release_out();

    // Zero/out-of-range indices
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h99;
    issue(5'd20, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1);
    wb_valid = 1'b0;
    check("oor_rd_en", 32'({rb_read1, rb_read2}), 1);
    check("oor_wr0", 32'(rb_write), 0);
    step();
    check("oor_out_a", bus.out_a, 0);
    check("oor_out_b", bus.out_b, 3);
    check("oor_pend", 32'(dut.pend), 32'h50);
    wb_valid = 1'b1; wb_reg = 5'd20; wb_data = 32'hAA;
    step();
    wb_valid = 1'b0;
    check("oor_wr20", 32'(rb_write), 0);

    // Stall in HOLD, then reset
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_out_b", bus.out_b, 3);
      check("hold_in_ready", 32'(bus.in_ready), 0);
    end
    check("hold_pend", 32'(dut.pend), 32'h50);
    rst = 1'b1;
    step();
    check("mr_out_valid", 32'(bus.out_valid), 0);
    check("mr_pend", 32'(dut.pend), 0);
    check("mr_out_b", bus.out_b, 0);
    check("mr_stall", 32'(stall_cnt), 0);
    rst = 1'b0;
    #1;
    check("mr_idle", 32'(bus.in_ready), 1);

    // Stall counter saturation
    issue(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    step();
    release_out();
    issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (65534) step();
    check("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    step();
    check("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (4465) step();
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
    step();
    wb_valid = 1'b0;
    step();
    step();
    check("sat_out_a", bus.out_a, 32'h33);
    check("sat_final", 32'(stall_cnt), 32'hFFFF);
    release_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
